micro_sequencer: RTL
====================

# micro_sequencer

Parametrised microprogram sequencer for the control unit. It holds the control address register (CAR) and computes the next micro-address each cycle from a 3-bit sequencing opcode in the current control word. Beyond increment, dispatch and fetch-return, it adds a parametrised opcode dispatch map, flag-conditional branching, a bounded micro-subroutine stack, single-step parking and sticky error reporting. It sits between the control store (which it addresses) and the IR/flag registers (which it reads).

## Interface
- CAR_WIDTH, 7: micro-address width.
- OPCODE_WIDTH, 4: opcode field width.
- NUM_FLAGS, 4: condition flag count; CSEL_W = max(1, clog2(NUM_FLAGS)).
- STACK_DEPTH, 4: subroutine stack entries (≥1); DEPTH_W = clog2(STACK_DEPTH+1).
- FETCH_ADDR, 0: first fetch micro-instruction.
- INDIRECT_ADDR, 5: indirect-operand microroutine.
- PARK_ADDR, 32: step-mode NOP park address.
- DISPATCH_BASE, 5; DISPATCH_STRIDE, 2: opcode n maps to BASE + n·STRIDE.
---
- i_clk in 1: clock, rising edge.
- i_rst in 1: reset, asynchronous, active-high.
- i_cpu_start in 1: CPU run enable.
- i_step_mode in 1: single-instruction stepping.
- i_next_instr in 1: step stimulus.
- i_halt in 1: halt request (C23).
- i_seq_op in 3: sequencing opcode from the control word.
- i_branch_addr in CAR_WIDTH: literal target for branch and call.
- i_cond_sel in CSEL_W: flag index for branch.
- i_cond_inv in 1: invert selected flag.
- i_flags in NUM_FLAGS: ALU/status flags (ZF, NF, MF, ...).
- i_opcode in OPCODE_WIDTH; i_indirect in 1; i_opcode_valid in 1: IR opcode, addressing bit, capture strobe.
- o_car out CAR_WIDTH: micro-address, forced to 0 while i_cpu_start=0.
- o_stack_depth out DEPTH_W: occupied stack entries.
- o_stack_err out 1: sticky overflow/underflow.
- o_halted out 1: high while CAR is held by halt.

## Operation
- Opcode register: loads {i_indirect, i_opcode} when i_opcode_valid=1, holds otherwise. Dispatch reads only this register.
- Per-instruction flag `ind_done` prevents a second indirect pass.
- i_seq_op decode, priority as listed:
  - 000 HOLD: CAR unchanged.
  - 001 INC: CAR+1, wrapping mod 2^CAR_WIDTH.
  - 010 DISPATCH:
    - If the latched indirect bit=1, opcode≠0 and ind_done=0: CAR=INDIRECT_ADDR and set ind_done.
    - Otherwise, if opcode=0: CAR=FETCH_ADDR.
    - Otherwise: CAR = (DISPATCH_BASE + opcode·DISPATCH_STRIDE), truncated to CAR_WIDTH.
  - 011 FETCH:
    - If i_halt: CAR holds and o_halted=1.
    - Else if i_step_mode and !i_next_instr: CAR=PARK_ADDR.
    - Else: CAR=FETCH_ADDR, clear ind_done, clear the stack (depth→0).
  - 100 BRANCH: if i_flags[i_cond_sel]^i_cond_inv, CAR=i_branch_addr; else CAR+1. A cond_sel ≥ NUM_FLAGS reads the flag as 0.
  - 101 CALL:
    - Push CAR+1, then CAR=i_branch_addr.
    - Stack full: no push, jump still taken, o_stack_err=1.
  - 110 RETURN:
    - Pop into CAR.
    - Stack empty: CAR=FETCH_ADDR, o_stack_err=1.
  - 111: reserved, treated as HOLD.
- Start edge: a rising edge of i_cpu_start (registered compare) forces CAR=FETCH_ADDR, depth=0, ind_done=0, o_stack_err=0. This overrides i_seq_op.
- Stepping in park: PARK_ADDR microcode issues FETCH (011), so the sequencer re-parks until i_next_instr=1.

## Timing
- Reset (async, immediate): CAR=FETCH_ADDR, opcode reg=0, ind_done=0, depth=0, o_stack_err=0, o_halted=0, start-edge register=0. o_car reads 0 until i_cpu_start=1.
- All CAR updates are registered, with one-cycle latency. o_car is combinational from CAR and i_cpu_start.
- Dispatch uses the opcode register value from before the edge, so capture and dispatch in the same cycle dispatch the old opcode.
- Push and pop take one cycle each. Stack contents are not cleared, only depth.
- o_halted updates registered with CAR; it deasserts on the first non-held update.
- Reset mid-routine discards stack and state with no completion.

## Test plan
- Reset, start=1, op INC ×3 → o_car 0,1,2,3. Drop start → o_car=0. Re-raise start → CAR=0.
- Latch opcode 3, indirect=0, DISPATCH → o_car=11. Latch opcode 3 with indirect=1: first DISPATCH → 5, second → 11. FETCH, then the next indirect DISPATCH → 5 again.
- BRANCH with flags=4'b0001, cond_sel=0, inv=0, target 0x40 → 0x40. Same with inv=1 → CAR+1.
- STACK_DEPTH=2: CALL, CALL, CALL from CARs 10, 20, 30 → depth 2, err=1, CAR=target. RETURN, RETURN → 21, 11. RETURN on empty → CAR=0, err stays 1. Start edge → err=0.
- step_mode=1, FETCH without stimulus → 32, repeated. Pulse next_instr with FETCH → 0.
- halt=1 with FETCH → CAR holds, o_halted=1. Release halt → CAR=0, o_halted=0.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Bus bundle between the micro_sequencer and its surroundings:
// control-word fields, IR/flag inputs and the micro-address/status outputs.
interface micro_sequencer_if #(
  parameter int unsigned CAR_WIDTH    = 7,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned NUM_FLAGS    = 4,
  parameter int unsigned STACK_DEPTH  = 4
);
  localparam int unsigned CSEL_W  = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                    i_cpu_start;
  logic                    i_step_mode;
  logic                    i_next_instr;
  logic                    i_halt;
  logic [2:0]              i_seq_op;
  logic [CAR_WIDTH-1:0]    i_branch_addr;
  logic [CSEL_W-1:0]       i_cond_sel;
  logic                    i_cond_inv;
  logic [NUM_FLAGS-1:0]    i_flags;
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic                    i_indirect;
  logic                    i_opcode_valid;
  logic [CAR_WIDTH-1:0]    o_car;
  logic [DEPTH_W-1:0]      o_stack_depth;
  logic                    o_stack_err;
  logic                    o_halted;

  // Drives the sequencer (control store / IR / flag side)
  modport master (
    output i_cpu_start, i_step_mode, i_next_instr, i_halt, i_seq_op,
           i_branch_addr, i_cond_sel, i_cond_inv, i_flags,
           i_opcode, i_indirect, i_opcode_valid,
    input  o_car, o_stack_depth, o_stack_err, o_halted
  );

  // The sequencer itself
  modport slave (
    input  i_cpu_start, i_step_mode, i_next_instr, i_halt, i_seq_op,
           i_branch_addr, i_cond_sel, i_cond_inv, i_flags,
           i_opcode, i_indirect, i_opcode_valid,
    output o_car, o_stack_depth, o_stack_err, o_halted
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the control address register (CAR) and
// computes the next micro-address from the control word's sequencing opcode.
// Supports opcode dispatch with one indirect pass, flag branches, a bounded
// call/return stack, single-step parking, halt holding and sticky stack errors.
module micro_sequencer #(
  parameter int unsigned CAR_WIDTH       = 7,
  parameter int unsigned OPCODE_WIDTH    = 4,
  parameter int unsigned NUM_FLAGS       = 4,
  parameter int unsigned STACK_DEPTH     = 4,
  parameter int unsigned FETCH_ADDR      = 0,
  parameter int unsigned INDIRECT_ADDR   = 5,
  parameter int unsigned PARK_ADDR       = 32,
  parameter int unsigned DISPATCH_BASE   = 5,
  parameter int unsigned DISPATCH_STRIDE = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  micro_sequencer_if.slave bus
);
  localparam int unsigned CSEL_W  = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam logic [CAR_WIDTH-1:0] FETCH_A = CAR_WIDTH'(FETCH_ADDR);
  localparam logic [CAR_WIDTH-1:0] IND_A   = CAR_WIDTH'(INDIRECT_ADDR);
  localparam logic [CAR_WIDTH-1:0] PARK_A  = CAR_WIDTH'(PARK_ADDR);

  typedef enum logic [2:0] {
    SEQ_HOLD     = 3'b000,
    SEQ_INC      = 3'b001,
    SEQ_DISPATCH = 3'b010,
    SEQ_FETCH    = 3'b011,
    SEQ_BRANCH   = 3'b100,
    SEQ_CALL     = 3'b101,
    SEQ_RETURN   = 3'b110,
    SEQ_RSVD     = 3'b111
  } seq_op_e;

  seq_op_e seq_op;
  assign seq_op = seq_op_e'(bus.i_seq_op);

  logic [CAR_WIDTH-1:0]    car_q, car_d;
  logic [OPCODE_WIDTH:0]   op_q, op_d;          // {indirect, opcode}
  logic                    ind_done_q, ind_done_d;
  logic [DEPTH_W-1:0]      depth_q, depth_d;
  logic                    err_q, err_d;
  logic                    halted_q, halted_d;
  logic                    start_q, start_d;
  logic [CAR_WIDTH-1:0]    stack_q [STACK_DEPTH];
  logic [CAR_WIDTH-1:0]    stack_d [STACK_DEPTH];

  logic                    start_edge;
  logic [CAR_WIDTH-1:0]    car_inc;
  logic [OPCODE_WIDTH-1:0] op_code;
  logic                    op_ind;
  logic                    flag_sel;
  logic                    stack_full;
  logic                    stack_empty;
  logic [CAR_WIDTH-1:0]    pop_val;
  logic                    push_en;

  assign start_edge  = bus.i_cpu_start & ~start_q;
  assign car_inc     = car_q + CAR_WIDTH'(1);
  assign op_code     = op_q[OPCODE_WIDTH-1:0];
  assign op_ind      = op_q[OPCODE_WIDTH];
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);

  // Selected condition flag; indices past NUM_FLAGS read as 0
  always_comb begin
    flag_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
      if (bus.i_cond_sel == CSEL_W'(i)) flag_sel = bus.i_flags[i];
    end
  end

  // Top-of-stack read for RETURN
  always_comb begin
    pop_val = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) pop_val = stack_q[i];
    end
  end

  // Next-state decode; state only advances while the CPU is running, and a
  // start edge overrides whatever the control word asks for
  always_comb begin
    car_d      = car_q;
    ind_done_d = ind_done_q;
    depth_d    = depth_q;
    err_d      = err_q;
    halted_d   = halted_q;
    push_en    = 1'b0;
    start_d    = bus.i_cpu_start;
    op_d       = bus.i_opcode_valid ? {bus.i_indirect, bus.i_opcode} : op_q;

    if (start_edge) begin
      car_d      = FETCH_A;
      depth_d    = '0;
      ind_done_d = 1'b0;
      err_d      = 1'b0;
      halted_d   = 1'b0;
    end else if (bus.i_cpu_start) begin
      halted_d = 1'b0;
      unique case (seq_op)
        SEQ_INC: car_d = car_inc;
        SEQ_DISPATCH: begin
          if (op_ind && (op_code != '0) && !ind_done_q) begin
            car_d      = IND_A;
            ind_done_d = 1'b1;
          end else if (op_code == '0) begin
            car_d = FETCH_A;
          end else begin
            car_d = CAR_WIDTH'(DISPATCH_BASE + DISPATCH_STRIDE * 32'(op_code));
          end
        end
        SEQ_FETCH: begin
          if (bus.i_halt) begin
            halted_d = 1'b1;
          end else if (bus.i_step_mode && !bus.i_next_instr) begin
            car_d = PARK_A;
          end else begin
            car_d      = FETCH_A;
            ind_done_d = 1'b0;
            depth_d    = '0;
          end
        end
        SEQ_BRANCH: car_d = (flag_sel ^ bus.i_cond_inv) ? bus.i_branch_addr : car_inc;
        SEQ_CALL: begin
          car_d = bus.i_branch_addr;
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
          end
        end
        SEQ_RETURN: begin
          if (stack_empty) begin
            car_d = FETCH_A;
            err_d = 1'b1;
          end else begin
            car_d   = pop_val;
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default: car_d = car_q;   // HOLD and reserved
      endcase
    end
  end

  // Stack write port: return address lands in the slot above the current top
  always_comb begin
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (push_en && (depth_q == DEPTH_W'(i))) stack_d[i] = car_inc;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      car_q      <= FETCH_A;
      op_q       <= '0;
      ind_done_q <= 1'b0;
      depth_q    <= '0;
      err_q      <= 1'b0;
      halted_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      car_q      <= car_d;
      op_q       <= op_d;
      ind_done_q <= ind_done_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      halted_q   <= halted_d;
      start_q    <= start_d;
    end
  end

  // Stack storage; only depth is reset, entries are left as written
  always_ff @(posedge i_clk) begin
    stack_q <= stack_d;
  end

  assign bus.o_car         = bus.i_cpu_start ? car_q : '0;
  assign bus.o_stack_depth = depth_q;
  assign bus.o_stack_err   = err_q;
  assign bus.o_halted      = halted_q;
endmodule
